// File: rtl/mips_ctrl_sequencer.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITE_BACK FSM with a halt state.
// Define MIPS_CTRL_MULDIV_EN to give MULT/MULTU/DIV/DIVU a counted MDIV_WAIT phase before HI/LO write.
module mips_ctrl_sequencer #(
    parameter int MDIV_LATENCY = 32,
    parameter int STATE_W      = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func_code,
    input  logic [4:0]         rt_code,
    input  logic               waitrequest,
    input  logic               pc_is_zero,
    output logic [STATE_W-1:0] state,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               pc_write,
    output logic               hilo_write,
    output logic               instr_done,
    output logic               active
);

    typedef enum logic [2:0] {
        S_FETCH         = 3'd0,
        S_DECODE        = 3'd1,
        S_EXECUTE       = 3'd2,
        S_MEMORY_ACCESS = 3'd3,
        S_WRITE_BACK    = 3'd4,
        S_HALTED        = 3'd5,
        S_MDIV_WAIT     = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_LOAD,
        CLS_STORE,
        CLS_HILO,
        CLS_JUMP,
        CLS_MDIV
    } cls_e;

    if (MDIV_LATENCY < 1 || MDIV_LATENCY > 63) begin : g_bad_latency
        $error("mips_ctrl_sequencer: MDIV_LATENCY must be within 1..63");
    end

`ifdef MIPS_CTRL_MULDIV_EN
    localparam cls_e            MULDIV_CLS = CLS_MDIV;
    localparam logic [5:0]      MDIV_LOAD  = 6'(MDIV_LATENCY - 1);
    logic [5:0] count_q;
    logic [5:0] count_d;
`else
    // Without the multi-cycle unit, mul/div retire like MTHI/MTLO.
    localparam cls_e            MULDIV_CLS = CLS_HILO;
`endif

    state_e state_q;
    state_e state_d;
    cls_e   cls_q;
    cls_e   cls_d;

    logic mem_read_c;
    logic mem_write_c;
    logic ir_write_c;
    logic pc_write_c;
    logic hilo_write_c;
    logic instr_done_c;

    // rt_code is carried on the port for REGIMM decoding that this sequencer does not need.
    logic unused_rt;
    assign unused_rt = &{1'b0, rt_code};

    function automatic cls_e decode(input logic [5:0] op, input logic [5:0] fn);
        cls_e c;
        c = CLS_NOP;
        case (op)
            6'h00: begin
                case (fn)
                    6'h08, 6'h09:               c = CLS_JUMP;
                    6'h11, 6'h13:               c = CLS_HILO;
                    6'h18, 6'h19, 6'h1A, 6'h1B: c = MULDIV_CLS;
                    default:                    c = CLS_NOP;
                endcase
            end
            6'h02, 6'h03:                       c = CLS_JUMP;
            6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26:                c = CLS_LOAD;
            6'h28, 6'h29, 6'h2B:                c = CLS_STORE;
            default:                            c = CLS_NOP;
        endcase
        return c;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cls_q   <= CLS_NOP;
`ifdef MIPS_CTRL_MULDIV_EN
            count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
`ifdef MIPS_CTRL_MULDIV_EN
            count_q <= count_d;
`endif
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
`ifdef MIPS_CTRL_MULDIV_EN
        count_d      = count_q;
`endif
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        hilo_write_c = 1'b0;
        instr_done_c = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                if (!waitrequest) begin
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                ir_write_c = 1'b1;
                state_d    = S_EXECUTE;
            end
            S_EXECUTE: begin
                // The instruction class is latched here so later outputs never look at opcode.
                cls_d   = decode(opcode, func_code);
                state_d = S_MEMORY_ACCESS;
`ifdef MIPS_CTRL_MULDIV_EN
                if (cls_d == CLS_MDIV) begin
                    count_d = MDIV_LOAD;
                    state_d = S_MDIV_WAIT;
                end
`endif
            end
            S_MEMORY_ACCESS: begin
                case (cls_q)
                    CLS_LOAD: begin
                        mem_read_c = 1'b1;
                        if (!waitrequest) state_d = S_WRITE_BACK;
                    end
                    CLS_STORE: begin
                        mem_write_c = 1'b1;
                        if (!waitrequest) begin
                            instr_done_c = 1'b1;
                            state_d      = S_FETCH;
                        end
                    end
                    CLS_HILO: begin
                        hilo_write_c = 1'b1;
                        instr_done_c = 1'b1;
                        state_d      = S_FETCH;
                    end
                    CLS_JUMP: begin
                        instr_done_c = 1'b1;
                        state_d      = pc_is_zero ? S_HALTED : S_FETCH;
                    end
                    default: begin
                        instr_done_c = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_WRITE_BACK: begin
                instr_done_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
`ifdef MIPS_CTRL_MULDIV_EN
            S_MDIV_WAIT: begin
                if (count_q == 6'd0) begin
                    hilo_write_c = 1'b1;
                    instr_done_c = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    count_d = count_q - 6'd1;
                end
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Strobes are masked while reset is held so FETCH does not issue a read before release.
    assign mem_read   = mem_read_c   & reset_n;
    assign mem_write  = mem_write_c  & reset_n;
    assign ir_write   = ir_write_c   & reset_n;
    assign pc_write   = pc_write_c   & reset_n;
    assign hilo_write = hilo_write_c & reset_n;
    assign instr_done = instr_done_c & reset_n;
    assign active     = (state_q != S_HALTED);
    assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_ctrl_sequencer.sv
// Scoreboard bench for mips_ctrl_sequencer: per-cycle expected outputs are queued with the stimulus.
// Expectations follow MIPS_CTRL_MULDIV_EN if the macro is defined for the build.
module tb_mips_ctrl_sequencer;

    localparam int LAT = 12;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] func_code;
    logic [4:0] rt_code;
    logic       waitrequest;
    logic       pc_is_zero;
    logic [2:0] state;
    logic       mem_read, mem_write, ir_write, pc_write, hilo_write, instr_done, active;

    always #5 clk = ~clk;

    mips_ctrl_sequencer #(.MDIV_LATENCY(LAT), .STATE_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .func_code  (func_code),
        .rt_code    (rt_code),
        .waitrequest(waitrequest),
        .pc_is_zero (pc_is_zero),
        .state      (state),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .hilo_write (hilo_write),
        .instr_done (instr_done),
        .active     (active)
    );

    // Observed vector layout: {state[2:0], mem_read, mem_write, ir_write, pc_write, hilo_write, instr_done, active}
    logic [9:0] obs;
    assign obs = {state, mem_read, mem_write, ir_write, pc_write, hilo_write, instr_done, active};

    typedef struct {
        string      tag;
        logic       wr;
        logic       scramble;
        logic [9:0] exp;
    } step_t;

    step_t sb[$];
    int    total = 0;
    int    bad   = 0;

    function automatic logic [9:0] pk(input logic [2:0] st, input logic mr, input logic mw,
                                      input logic ir, input logic pw, input logic hw,
                                      input logic dn, input logic act);
        return {st, mr, mw, ir, pw, hw, dn, act};
    endfunction

    task automatic check(input string tag, input logic [9:0] o, input logic [9:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic push(input string tag, input logic wr, input logic scr, input logic [9:0] e);
        step_t s;
        s.tag      = tag;
        s.wr       = wr;
        s.scramble = scr;
        s.exp      = e;
        sb.push_back(s);
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic pcz);
        opcode     = op;
        func_code  = fn;
        pc_is_zero = pcz;
        rt_code    = 5'd0;
    endtask

    task automatic push_front_end(input int fetch_waits);
        for (int i = 0; i < fetch_waits; i++)
            push("fetch_stall", 1'b1, 1'b0, pk(3'd0, 1, 0, 0, 0, 0, 0, 1));
        push("fetch_go", 1'b0, 1'b0, pk(3'd0, 1, 0, 0, 1, 0, 0, 1));
        push("decode",   1'b0, 1'b0, pk(3'd1, 0, 0, 1, 0, 0, 0, 1));
        push("execute",  1'b0, 1'b0, pk(3'd2, 0, 0, 0, 0, 0, 0, 1));
    endtask

    task automatic push_muldiv(input logic scr);
`ifdef MIPS_CTRL_MULDIV_EN
        for (int i = 0; i < LAT - 1; i++)
            push("mdiv_wait", 1'b0, scr, pk(3'd6, 0, 0, 0, 0, 0, 0, 1));
        push("mdiv_last", 1'b0, scr, pk(3'd6, 0, 0, 0, 0, 1, 1, 1));
`else
        push("muldiv_mem", 1'b0, scr, pk(3'd3, 0, 0, 0, 0, 1, 1, 1));
`endif
    endtask

    // Called at 1 time unit after a rising edge; returns at the same phase.
    task automatic drain();
        step_t s;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            waitrequest = s.wr;
            if (s.scramble) begin
                opcode      = 6'($urandom);
                func_code   = 6'($urandom);
                rt_code     = 5'($urandom);
                waitrequest = 1'($urandom);
                pc_is_zero  = 1'($urandom);
            end
            @(negedge clk);
            check(s.tag, obs, s.exp);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        waitrequest = 1'b0;
        set_instr(6'h00, 6'h00, 1'b0);
        #2;
        check("reset_async", obs, pk(3'd0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk);
        #1;
        check("reset_held", obs, pk(3'd0, 0, 0, 0, 0, 0, 0, 1));
        reset_n = 1'b1;

        // ADDU: 0,1,2,3 then back to FETCH, done on the MEMORY_ACCESS cycle
        set_instr(6'h00, 6'h21, 1'b0);
        push_front_end(0);
        push("addu_mem", 1'b0, 1'b0, pk(3'd3, 0, 0, 0, 0, 0, 1, 1));
        drain();

        // LW with three stalled memory cycles
        set_instr(6'h23, 6'h00, 1'b0);
        push_front_end(0);
        for (int i = 0; i < 3; i++)
            push("lw_stall", 1'b1, 1'b0, pk(3'd3, 1, 0, 0, 0, 0, 0, 1));
        push("lw_go", 1'b0, 1'b0, pk(3'd3, 1, 0, 0, 0, 0, 0, 1));
        push("lw_wb", 1'b0, 1'b0, pk(3'd4, 0, 0, 0, 0, 0, 1, 1));
        drain();

        // SW with two stalled memory cycles
        set_instr(6'h2B, 6'h00, 1'b0);
        push_front_end(0);
        for (int i = 0; i < 2; i++)
            push("sw_stall", 1'b1, 1'b0, pk(3'd3, 0, 1, 0, 0, 0, 0, 1));
        push("sw_go", 1'b0, 1'b0, pk(3'd3, 0, 1, 0, 0, 0, 1, 1));
        drain();

        // Fetch stalled five cycles, then an undefined opcode retires as NOP
        set_instr(6'h3F, 6'h00, 1'b0);
        push_front_end(5);
        push("nop_mem", 1'b0, 1'b0, pk(3'd3, 0, 0, 0, 0, 0, 1, 1));
        drain();

        // MTHI writes HI/LO in MEMORY_ACCESS
        set_instr(6'h00, 6'h11, 1'b0);
        push_front_end(0);
        push("mthi_mem", 1'b0, 1'b0, pk(3'd3, 0, 0, 0, 0, 1, 1, 1));
        drain();

        // MULT with random inputs during the wait, then DIVU held steady
        set_instr(6'h00, 6'h18, 1'b0);
        push_front_end(0);
        push_muldiv(1'b1);
        drain();
        set_instr(6'h00, 6'h1B, 1'b0);
        push_front_end(0);
        push_muldiv(1'b0);
        drain();

        // J to a nonzero target keeps running
        set_instr(6'h02, 6'h00, 1'b0);
        push_front_end(0);
        push("j_mem", 1'b0, 1'b0, pk(3'd3, 0, 0, 0, 0, 0, 1, 1));
        drain();

        // Reset during a stalled load access
        set_instr(6'h20, 6'h00, 1'b0);
        push_front_end(0);
        push("lb_stall", 1'b1, 1'b0, pk(3'd3, 1, 0, 0, 0, 0, 0, 1));
        drain();
        waitrequest = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_mid_load", obs, pk(3'd0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

`ifdef MIPS_CTRL_MULDIV_EN
        // Reset while the counter holds 10, then a full-length MULT
        set_instr(6'h00, 6'h18, 1'b0);
        push_front_end(0);
        push("mdiv_c11", 1'b0, 1'b0, pk(3'd6, 0, 0, 0, 0, 0, 0, 1));
        drain();
        #1;
        check("mdiv_c10", obs, pk(3'd6, 0, 0, 0, 0, 0, 0, 1));
        reset_n = 1'b0;
        #1;
        check("reset_mid_mdiv", obs, pk(3'd0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        set_instr(6'h00, 6'h19, 1'b0);
        push_front_end(0);
        push_muldiv(1'b0);
        drain();
`endif

        // JR to address zero halts; HALTED ignores random inputs
        set_instr(6'h00, 6'h08, 1'b1);
        push_front_end(0);
        push("jr_mem", 1'b0, 1'b0, pk(3'd3, 0, 0, 0, 0, 0, 1, 1));
        for (int i = 0; i < 20; i++)
            push("halted", 1'b0, 1'b1, pk(3'd5, 0, 0, 0, 0, 0, 0, 0));
        drain();
        reset_n = 1'b0;
        #1;
        check("reset_from_halt", obs, pk(3'd0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Sequencer runs again after leaving HALTED
        set_instr(6'h00, 6'h21, 1'b0);
        push_front_end(0);
        push("addu_after_halt", 1'b0, 1'b0, pk(3'd3, 0, 0, 0, 0, 0, 1, 1));
        push("fetch_after", 1'b0, 1'b0, pk(3'd0, 1, 0, 0, 1, 0, 0, 1));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
